dot_product_accumulator: RTL and testbench
==========================================

# dot_product_accumulator

Downstream stage of the 16×16 signed sequential multiplier: consumes each product the multiplier presents on `ready_bit` and sums a programmed number of them into a wide signed accumulator. It then holds the finished dot product on a valid/ready output until taken. It sits between the multiplier and the result writeback logic, letting the multiplier run back-to-back operand pairs without software summing partial products.

## Interface
- `PROD_W`, 32: multiplier product width (signed).
- `ACC_W`, 38: accumulator width (signed); must be ≥ `PROD_W`.
- `LEN_W`, 8: width of the vector-length field; max length 2^LEN_W−1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `acc_start`  in  1  one-cycle pulse; begins a new accumulation.
- `len`  in  LEN_W  number of products to sum; sampled with `acc_start`.
- `ready_bit`  in  1  multiplier result-ready level.
- `product`  in  PROD_W  multiplier product; valid while `ready_bit`=1.
- `acc_ready`  in  1  consumer accepts `acc_out`.
- `acc_valid`  out  1  `acc_out` holds a finished sum.
- `acc_out`  out  ACC_W  accumulated sum.
- `busy`  out  1  high in ACCUM and HOLD.
- `overflow`  out  1  sticky; sum saturated (`SATURATE_EN` only).
- `lost`  out  1  sticky; a product arrived while not in ACCUM.

## Operation
- States: IDLE, ACCUM, HOLD.
- Capture event: `ready_bit`=1 at a rising edge while the registered previous value was 0 (rising-edge detect). A level held high for many cycles counts once.
- IDLE:
  - `acc_start`=1 clears the accumulator and count to 0 and latches `len`.
  - If `len`=0, go to HOLD with sum 0; otherwise go to ACCUM.
  - A capture event in IDLE sets `lost`. If it coincides with `acc_start`, the start is taken and the product is not summed.
- ACCUM:
  - Each capture event adds sign-extended `product` to the accumulator and increments the count.
  - The capture that brings the count to `len` goes to HOLD.
  - `acc_start` in ACCUM is ignored.
- HOLD:
  - `acc_valid`=1 and `acc_out` stable.
  - `acc_ready`=1 returns to IDLE on that edge.
  - A capture event in HOLD sets `lost`; the product is discarded.
  - `acc_start` in HOLD is ignored.
- `lost` and `overflow` clear only on reset or on an accepted `acc_start`.
- Arithmetic: the full-width signed add is computed at ACC_W+1 bits and then reduced to ACC_W per Configuration.

## Timing
- Reset values: state IDLE; `acc_valid`, `busy`, `overflow` and `lost` all 0; `acc_out`=0; count 0; edge-detect register 0.
- Reset mid-accumulation aborts immediately. No partial result is emitted.
- Start latency: `busy`=1 the cycle after the `acc_start` edge.
- Capture: the accumulator updates at the edge that detects the rise.
- Result latency: `acc_valid` is a registered Moore output. It rises the cycle after the final capture edge, or the cycle after `acc_start` when `len`=0.
- Handshake: the transfer completes on an edge with `acc_valid`&`acc_ready`. `acc_valid` falls the next cycle.
- Back-to-back: the earliest new `acc_start` is accepted the cycle after the handshake edge.

## Configuration
- `DOT_ACC_SATURATE_EN` defined:
  - On ACC_W+1 overflow, the sum clamps to 2^(ACC_W−1)−1 or −2^(ACC_W−1).
  - `overflow` sets and is sticky.
  - Once saturated, the accumulator keeps summing from the clamped value.
- Undefined:
  - The sum wraps in two's complement (low ACC_W bits).
  - `overflow` is tied 0.

## Structure
- Package `dot_acc_pkg`:
  - state enum `acc_state_t` (IDLE, ACCUM, HOLD);
  - default width constants;
  - `ACC_MAX` and `ACC_MIN` localparams for the default ACC_W.
- Sub-module `ready_edge_detect`: registers `ready_bit` and outputs a one-cycle `capture` pulse. It resets asynchronously on `rst`=0.

## Test plan
- `len`=3, products 100, −50, 7, each a one-cycle `ready_bit` pulse → `acc_out`=57, `acc_valid` the cycle after the third pulse, `lost`=0.
- `len`=2, `ready_bit` held high 5 cycles with product 1000, then low, then a pulse with −1 → `acc_out`=999 (the held level counts once).
- `len`=0 → `acc_valid`=1 the cycle after `acc_start`, `acc_out`=0.
- HOLD with `acc_ready`=0 for 10 cycles plus an extra `ready_bit` pulse → `acc_out` stable, `lost`=1. Then `acc_ready`=1 → IDLE. The next `acc_start` clears `lost`.
- `len`=200, every product 1073741824 (32767·… max, 2^30), ACC_W=38:
  - with `DOT_ACC_SATURATE_EN` → `acc_out`=137438953471, `overflow`=1;
  - without → `acc_out`=(200·2^30) mod 2^38 as signed = −60129542144, `overflow`=0.
- `rst` pulled low after the 2nd of 4 products → all outputs 0 at once. After release, a fresh `len`=1 run with product −32768·32767 gives `acc_out`=−1073709056.

Source files
------------

// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and default widths for the dot-product accumulator.
package dot_acc_pkg;

  localparam int unsigned PROD_W_DEF = 32;
  localparam int unsigned ACC_W_DEF  = 38;
  localparam int unsigned LEN_W_DEF  = 8;

  // Saturation limits for the default accumulator width.
  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Product input / result output bundle of the dot-product accumulator.
// slave: the accumulator side; master: the driving/consuming side.
interface dot_product_accumulator_if
  import dot_acc_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) ();

  logic              acc_start;
  logic [LEN_W-1:0]  len;
  logic              ready_bit;
  logic [PROD_W-1:0] product;
  logic              acc_ready;
  logic              acc_valid;
  logic [ACC_W-1:0]  acc_out;
  logic              busy;
  logic              overflow;
  logic              lost;

  modport slave (
    input  acc_start, len, ready_bit, product, acc_ready,
    output acc_valid, acc_out, busy, overflow, lost
  );

  modport master (
    output acc_start, len, ready_bit, product, acc_ready,
    input  acc_valid, acc_out, busy, overflow, lost
  );

endinterface

// File: rtl/dot_product_accumulator_ready_edge_detect.sv
// Rising-edge detector on the multiplier ready level: one capture pulse per rise.
module ready_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic ready_bit,
  output logic capture
);

  logic ready_q;

  // Remember last cycle's ready level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_bit;
    end
  end

  assign capture = ready_bit & ~ready_q;

endmodule

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: sums a programmed number of multiplier products
// and holds the result on a valid/ready output.
// Optional feature: define DOT_ACC_SATURATE_EN for saturating accumulation
// with a sticky overflow flag; otherwise the sum wraps and overflow is 0.
module dot_product_accumulator
  import dot_acc_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input logic                      clk,
  input logic                      rst,
  dot_product_accumulator_if.slave bus
);

  acc_state_t        state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_nxt;
  logic              valid_q;
  logic              busy_q;
  logic              lost_q;
  logic              capture;
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0]  sum_next;

`ifdef DOT_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0] sum_wide;
  logic           sum_ovf;
  logic           ovf_q;
`endif

  ready_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .ready_bit (bus.ready_bit),
    .capture   (capture)
  );

  assign count_nxt = count_q + LEN_W'(1);

  // Next accumulator value: sign-extended product added to the running sum.
  always_comb begin
    prod_ext = ACC_W'($signed(bus.product));
`ifdef DOT_ACC_SATURATE_EN
    sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (sum_ovf) begin
      sum_next = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_next = sum_wide[ACC_W-1:0];
    end
`else
    // Wrapping keeps only the low ACC_W bits, so the carry bit is never formed.
    sum_next = acc_q + prod_ext;
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      lost_q  <= 1'b0;
`ifdef DOT_ACC_SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.acc_start) begin
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= bus.len;
            // A coincident capture is not summed but still counts as lost.
            lost_q  <= capture;
`ifdef DOT_ACC_SATURATE_EN
            ovf_q   <= 1'b0;
`endif
            busy_q  <= 1'b1;
            if (bus.len == '0) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end else if (capture) begin
            lost_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (capture) begin
            acc_q   <= sum_next;
            count_q <= count_nxt;
`ifdef DOT_ACC_SATURATE_EN
            if (sum_ovf) begin
              ovf_q <= 1'b1;
            end
`endif
            if (count_nxt == len_q) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (capture) begin
            lost_q <= 1'b1;
          end
          if (bus.acc_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_valid = valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.busy      = busy_q;
  assign bus.lost      = lost_q;
`ifdef DOT_ACC_SATURATE_EN
  assign bus.overflow  = ovf_q;
`else
  assign bus.overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator (scoreboarded results).
module tb_dot_product_accumulator;
  import dot_acc_pkg::*;

  localparam int ACC_W = ACC_W_DEF;

  typedef struct {
    longint sum;
    bit     ovf;
    bit     lost;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dot_product_accumulator_if bus ();

  dot_product_accumulator #(
    .PROD_W (PROD_W_DEF),
    .ACC_W  (ACC_W_DEF),
    .LEN_W  (LEN_W_DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int unsigned n);
    bus.len       = n[LEN_W_DEF-1:0];
    bus.acc_start = 1'b1;
    tick();
    bus.acc_start = 1'b0;
  endtask

  task automatic pulse(input longint p);
    bus.product   = p[PROD_W_DEF-1:0];
    bus.ready_bit = 1'b1;
    tick();
    bus.ready_bit = 1'b0;
    tick();
  endtask

  // Final product of a run: leaves the bench just after the capturing edge.
  task automatic rise(input longint p);
    bus.product   = p[PROD_W_DEF-1:0];
    bus.ready_bit = 1'b1;
    tick();
    bus.ready_bit = 1'b0;
  endtask

  task automatic model_add(inout longint acc, inout bit ovf, input longint p);
    longint s;
    logic [63:0] t;
    s = acc + p;
`ifdef DOT_ACC_SATURATE_EN
    t = '0;
    if (s > ((longint'(1) <<< (ACC_W - 1)) - 1)) begin
      s = (longint'(1) <<< (ACC_W - 1)) - 1;
      ovf = 1'b1;
    end else if (s < -(longint'(1) <<< (ACC_W - 1))) begin
      s = -(longint'(1) <<< (ACC_W - 1));
      ovf = 1'b1;
    end
`else
    t = s;
    s = longint'($signed(t[ACC_W-1:0]));
`endif
    acc = s;
  endtask

  task automatic handshake();
    bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.acc_start = 1'b0;
    bus.len       = '0;
    bus.ready_bit = 1'b0;
    bus.product   = '0;
    bus.acc_ready = 1'b0;
    #22;
    checks++;
    if ({bus.acc_valid, bus.busy, bus.overflow, bus.lost} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: valid/busy/ovf/lost=%b expected 0000",
               {bus.acc_valid, bus.busy, bus.overflow, bus.lost});
    end
    checks++;
    if (bus.acc_out !== '0) begin
      errors++;
      $display("FAIL reset_acc_out: got %0d expected 0", $signed(bus.acc_out));
    end
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    longint acc = 0;
    bit ovf = 1'b0;
    exp_t e;
    logic [ACC_W+1:0] got, want;
    start(3);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b expected 1", bus.busy);
    end
    pulse(100);  model_add(acc, ovf, 100);
    start(0);    // must be ignored while accumulating
    pulse(-50);  model_add(acc, ovf, -50);
    checks++;
    if (bus.acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %b expected 0", bus.acc_valid);
    end
    model_add(acc, ovf, 7);
    sb.push_back('{acc, ovf, 1'b0});
    rise(7);
    checks++;
    if (bus.acc_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid_latency: got %b expected 1", bus.acc_valid);
    end
    e = sb.pop_front();
    got  = {bus.acc_out, bus.overflow, bus.lost};
    want = {e.sum[ACC_W-1:0], e.ovf, e.lost};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL basic_result: acc_out=%0d ovf=%b lost=%b expected acc_out=%0d ovf=%b lost=%b",
               $signed(bus.acc_out), bus.overflow, bus.lost, e.sum, e.ovf, e.lost);
    end
    handshake();
    checks++;
    if ({bus.acc_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_after_handshake: valid/busy=%b expected 00", {bus.acc_valid, bus.busy});
    end
  endtask

  task automatic test_held_level();
    exp_t e;
    logic [ACC_W+1:0] got, want;
    start(2);
    bus.product   = 32'd1000;
    bus.ready_bit = 1'b1;
    repeat (5) tick();
    bus.ready_bit = 1'b0;
    tick();
    checks++;
    if (bus.acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_counted_once: valid=%b expected 0", bus.acc_valid);
    end
    sb.push_back('{999, 1'b0, 1'b0});
    rise(-1);
    e = sb.pop_front();
    got  = {bus.acc_valid, bus.acc_out, bus.lost};
    want = {1'b1, e.sum[ACC_W-1:0], e.lost};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL held_result: valid=%b acc_out=%0d lost=%b expected valid=1 acc_out=%0d lost=%b",
               bus.acc_valid, $signed(bus.acc_out), bus.lost, e.sum, e.lost);
    end
    handshake();
  endtask

  task automatic test_len_zero();
    exp_t e;
    sb.push_back('{0, 1'b0, 1'b0});
    start(0);
    e = sb.pop_front();
    checks++;
    if ({bus.acc_valid, bus.acc_out} !== {1'b1, e.sum[ACC_W-1:0]}) begin
      errors++;
      $display("FAIL len_zero: valid=%b acc_out=%0d expected valid=1 acc_out=%0d",
               bus.acc_valid, $signed(bus.acc_out), e.sum);
    end
    handshake();
  endtask

  task automatic test_hold_lost();
    exp_t e;
    logic [ACC_W-1:0] held;
    sb.push_back('{5, 1'b0, 1'b0});
    start(1);
    rise(5);
    e = sb.pop_front();
    checks++;
    if ({bus.acc_valid, bus.acc_out, bus.lost} !== {1'b1, e.sum[ACC_W-1:0], e.lost}) begin
      errors++;
      $display("FAIL hold_result: valid=%b acc_out=%0d lost=%b expected valid=1 acc_out=%0d lost=%b",
               bus.acc_valid, $signed(bus.acc_out), bus.lost, e.sum, e.lost);
    end
    held = bus.acc_out;
    for (int i = 0; i < 10; i++) begin
      bus.product   = 32'd77;
      bus.ready_bit = (i == 3);
      tick();
      checks++;
      if ({bus.acc_valid, bus.acc_out} !== {1'b1, e.sum[ACC_W-1:0]}) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b acc_out=%0d expected valid=1 acc_out=%0d",
                 i, bus.acc_valid, $signed(bus.acc_out), $signed(held));
      end
    end
    bus.ready_bit = 1'b0;
    checks++;
    if (bus.lost !== 1'b1) begin
      errors++;
      $display("FAIL hold_lost_set: got %b expected 1", bus.lost);
    end
    handshake();
    checks++;
    if ({bus.acc_valid, bus.lost} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release: valid/lost=%b expected 01", {bus.acc_valid, bus.lost});
    end
    start(1);
    checks++;
    if (bus.lost !== 1'b0) begin
      errors++;
      $display("FAIL hold_lost_clear: got %b expected 0", bus.lost);
    end
    rise(3);
    handshake();
  endtask

  task automatic test_overflow();
    longint acc = 0;
    bit ovf = 1'b0;
    exp_t e;
    logic [ACC_W:0] got, want;
    start(200);
    for (int i = 0; i < 199; i++) begin
      pulse(longint'(1) <<< 30);
      model_add(acc, ovf, longint'(1) <<< 30);
    end
    model_add(acc, ovf, longint'(1) <<< 30);
    sb.push_back('{acc, ovf, 1'b0});
    rise(longint'(1) <<< 30);
    e = sb.pop_front();
    got  = {bus.acc_out, bus.overflow};
    want = {e.sum[ACC_W-1:0], e.ovf};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL overflow_model: acc_out=%0d ovf=%b expected acc_out=%0d ovf=%b",
               $signed(bus.acc_out), bus.overflow, e.sum, e.ovf);
    end
`ifdef DOT_ACC_SATURATE_EN
    checks++;
    if ({bus.acc_out, bus.overflow} !== {ACC_MAX, 1'b1}) begin
      errors++;
      $display("FAIL overflow_saturate: acc_out=%0d ovf=%b expected 137438953471 ovf=1",
               $signed(bus.acc_out), bus.overflow);
    end
`else
    checks++;
    if ($signed(bus.acc_out) !== -38'sd60129542144 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_wrap: acc_out=%0d ovf=%b expected -60129542144 ovf=0",
               $signed(bus.acc_out), bus.overflow);
    end
`endif
    handshake();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    start(4);
    pulse(10);
    pulse(20);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.acc_valid, bus.busy, bus.overflow, bus.lost, bus.acc_out} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: valid=%b busy=%b ovf=%b lost=%b acc_out=%0d expected all 0",
               bus.acc_valid, bus.busy, bus.overflow, bus.lost, $signed(bus.acc_out));
    end
    #3 rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.acc_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_result: valid/busy=%b expected 00", {bus.acc_valid, bus.busy});
    end
    sb.push_back('{-1073709056, 1'b0, 1'b0});
    start(1);
    rise(-32768 * 32767);
    e = sb.pop_front();
    checks++;
    if ({bus.acc_valid, bus.acc_out} !== {1'b1, e.sum[ACC_W-1:0]}) begin
      errors++;
      $display("FAIL abort_fresh_run: valid=%b acc_out=%0d expected valid=1 acc_out=%0d",
               bus.acc_valid, $signed(bus.acc_out), e.sum);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back('{11, 1'b0, 1'b0});
    start(1);
    rise(11);
    e = sb.pop_front();
    checks++;
    if (bus.acc_out !== e.sum[ACC_W-1:0]) begin
      errors++;
      $display("FAIL b2b_first: acc_out=%0d expected %0d", $signed(bus.acc_out), e.sum);
    end
    handshake();
    sb.push_back('{-22, 1'b0, 1'b0});
    start(1);
    checks++;
    if ({bus.busy, bus.acc_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_start_taken: busy/valid=%b expected 10", {bus.busy, bus.acc_valid});
    end
    rise(-22);
    e = sb.pop_front();
    checks++;
    if ({bus.acc_valid, bus.acc_out} !== {1'b1, e.sum[ACC_W-1:0]}) begin
      errors++;
      $display("FAIL b2b_second: valid=%b acc_out=%0d expected valid=1 acc_out=%0d",
               bus.acc_valid, $signed(bus.acc_out), e.sum);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_level();
    test_len_zero();
    test_hold_lost();
    test_overflow();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
